// File: rtl/dmem_arbiter.sv
// Arbiter for the shared 8-bit data memory port. The CPU load/store path and
// the DMA/IO engine take turns round-robin. A requester can hold the port for
// a locked burst of up to MAX_BURST beats before it must hand the port over.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_lock,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [1:0]    owner
);

  localparam int CW = $clog2(MAX_BURST + 1);
  // cnt+1 < MAX_BURST is the same as cnt < MAX_BURST-1; this form cannot overflow
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWN_CPU = 2'b01,
    OWN_DMA = 2'b10
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last_dma, last_dma_n;  // 1 = DMA was the last owner

  // Control registers: ownership state, burst beat counter, round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dma <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_dma <= last_dma_n;
    end
  end

  // Next-state arbitration and memory-port steering for the current owner
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_dma_n = last_dma;
    cpu_ack    = 1'b0;
    dma_ack    = 1'b0;
    cpu_rdata  = '0;
    dma_rdata  = '0;
    mem_raddr  = '0;
    mem_waddr  = '0;
    mem_we     = 1'b0;
    mem_din    = '0;
    owner      = 2'b00;

    case (state)
      IDLE: begin
        if (cpu_req && dma_req) state_n = last_dma ? OWN_CPU : OWN_DMA;
        else if (cpu_req)       state_n = OWN_CPU;
        else if (dma_req)       state_n = OWN_DMA;
      end
      OWN_CPU: begin
        owner     = 2'b01;
        mem_raddr = cpu_addr;
        mem_waddr = cpu_addr;
        mem_din   = cpu_wdata;
        mem_we    = cpu_req & cpu_we;
        cpu_ack   = cpu_req;
        cpu_rdata = mem_dout;
        // Keep the port while locked, unless this beat uses up the burst budget
        if (cpu_lock && (!cpu_req || (cnt < BURST_LAST))) begin
          if (cpu_req) cnt_n = cnt + CW'(1);
        end else begin
          cnt_n      = '0;
          last_dma_n = 1'b0;
          state_n    = dma_req ? OWN_DMA : IDLE;
        end
      end
      OWN_DMA: begin
        owner     = 2'b10;
        mem_raddr = dma_addr;
        mem_waddr = dma_addr;
        mem_din   = dma_wdata;
        mem_we    = dma_req & dma_we;
        dma_ack   = dma_req;
        dma_rdata = mem_dout;
        if (dma_lock && (!dma_req || (cnt < BURST_LAST))) begin
          if (dma_req) cnt_n = cnt + CW'(1);
        end else begin
          cnt_n      = '0;
          last_dma_n = 1'b1;
          state_n    = cpu_req ? OWN_CPU : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A reset cycle must never complete a beat or trigger the negedge write
    if (rst) begin
      mem_we  = 1'b0;
      cpu_ack = 1'b0;
      dma_ack = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural data memory, directed per-cycle
// stimulus that queues the expected port view, and a monitor that pops and
// compares one entry each cycle.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, cpu_lock, cpu_ack;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dma_req, dma_we, dma_lock, dma_ack;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic [7:0] mem_raddr, mem_waddr, mem_din, mem_dout;
  logic       mem_we;
  logic [1:0] owner;

  logic [7:0] mem [0:255];

  typedef struct {
    logic [1:0] owner;
    logic       cack;
    logic       dack;
    logic       mwe;
    logic [7:0] addr;
    logic [7:0] din;
    logic       crd_en;
    logic [7:0] crd;
    logic       drd_en;
    logic [7:0] drd;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .owner(owner)
  );

  always #5 clk = ~clk;

  // DataMemory model: negedge write, asynchronous read
  always @(negedge clk) if (mem_we) mem[mem_waddr] <= mem_din;
  assign mem_dout = mem[mem_raddr];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare the port view against the queued expectation each cycle
  always begin
    @(posedge clk);
    #4;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("owner",     {6'd0, owner},   {6'd0, me.owner});
      chk("cpu_ack",   {7'd0, cpu_ack}, {7'd0, me.cack});
      chk("dma_ack",   {7'd0, dma_ack}, {7'd0, me.dack});
      chk("mem_we",    {7'd0, mem_we},  {7'd0, me.mwe});
      chk("mem_waddr", mem_waddr, me.addr);
      chk("mem_raddr", mem_raddr, me.addr);
      if (me.mwe)    chk("mem_din",   mem_din,   me.din);
      if (me.crd_en) chk("cpu_rdata", cpu_rdata, me.crd);
      if (me.drd_en) chk("dma_rdata", dma_rdata, me.drd);
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                     input logic l);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d; cpu_lock = l;
  endtask

  task automatic dma(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                     input logic l);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d; dma_lock = l;
  endtask

  task automatic push(input logic [1:0] o, input logic ca, input logic da, input logic w,
                      input logic [7:0] a, input logic [7:0] d, input logic cen,
                      input logic [7:0] crd, input logic den, input logic [7:0] drd);
    exp_t e;
    e.owner = o; e.cack = ca; e.dack = da; e.mwe = w; e.addr = a; e.din = d;
    e.crd_en = cen; e.crd = crd; e.drd_en = den; e.drd = drd;
    q.push_back(e);
  endtask

  task automatic e_idle();
    push(2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic e_cpu(input logic ack, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic rden, input logic [7:0] rd);
    push(2'b01, ack, 1'b0, w, a, d, rden, rd, 1'b1, 8'h00);
  endtask

  task automatic e_dma(input logic ack, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic rden, input logic [7:0] rd);
    push(2'b10, 1'b0, ack, w, a, d, 1'b1, 8'h00, rden, rd);
  endtask

  initial begin
    rst = 1'b1;
    cpu(0, 0, 8'h00, 8'h00, 0);
    dma(0, 0, 8'h00, 8'h00, 0);
    go(); e_idle();                                            // reset state

    // Single CPU write then read of 8'h1F
    go(); rst = 1'b0; cpu(1, 1, 8'h1F, 8'h07, 0); e_idle();
    go(); e_cpu(1, 1, 8'h1F, 8'h07, 0, 8'h00);
    go(); cpu(1, 0, 8'h1F, 8'h00, 0); e_idle();
    go(); e_cpu(1, 0, 8'h1F, 8'h00, 1, 8'h07);
    go(); cpu(0, 0, 8'h00, 8'h00, 0); e_idle();

    // Tie right after reset: CPU first, then direct hand-off to DMA
    go(); rst = 1'b1; e_idle();
    go(); rst = 1'b0; cpu(1, 0, 8'h1F, 8'h00, 0); dma(1, 1, 8'h20, 8'h5A, 0); e_idle();
    go(); e_cpu(1, 0, 8'h1F, 8'h00, 1, 8'h07);
    go(); cpu(0, 0, 8'h00, 8'h00, 0); e_dma(1, 1, 8'h20, 8'h5A, 0, 8'h00);
    go(); dma(0, 0, 8'h00, 8'h00, 0); e_idle();

    // Locked CPU burst capped at 4 beats with DMA waiting
    go(); cpu(1, 1, 8'h30, 8'h11, 1); dma(1, 1, 8'h40, 8'h22, 0); e_idle();
    for (int i = 0; i < 4; i++) begin
      go(); cpu(1, 1, 8'h30 + 8'(i), 8'h11 + 8'(i), 1);
      e_cpu(1, 1, 8'h30 + 8'(i), 8'h11 + 8'(i), 0, 8'h00);
    end
    go(); cpu(0, 0, 8'h00, 8'h00, 0); e_dma(1, 1, 8'h40, 8'h22, 0, 8'h00);
    // Next tie goes to the CPU
    go(); cpu(1, 0, 8'h30, 8'h00, 0); dma(1, 0, 8'h40, 8'h00, 0); e_idle();
    go(); e_cpu(1, 0, 8'h30, 8'h00, 1, 8'h11);
    go(); cpu(0, 0, 8'h00, 8'h00, 0); e_dma(1, 0, 8'h40, 8'h00, 1, 8'h22);

    // Idle hold under DMA lock, counter preserved across the hold
    go(); dma(1, 0, 8'h40, 8'h00, 1); e_idle();
    go(); e_dma(1, 0, 8'h40, 8'h00, 1, 8'h22);
    for (int i = 0; i < 3; i++) begin
      go(); dma(0, 0, 8'h40, 8'h00, 1); e_dma(0, 0, 8'h40, 8'h00, 0, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      go(); dma(1, 0, 8'h40, 8'h00, 1); e_dma(1, 0, 8'h40, 8'h00, 1, 8'h22);
    end
    go(); e_idle();                                            // forced release, re-request
    go(); e_dma(1, 0, 8'h40, 8'h00, 1, 8'h22);
    go(); dma(0, 0, 8'h40, 8'h00, 0); e_dma(0, 0, 8'h40, 8'h00, 0, 8'h00);
    go(); e_idle();

    // Reset in the 2nd beat of a locked DMA write burst to 8'hFF
    go(); dma(1, 1, 8'hFF, 8'hAA, 1); e_idle();
    go(); e_dma(1, 1, 8'hFF, 8'hAA, 0, 8'h00);
    go(); rst = 1'b1; dma(1, 1, 8'hFF, 8'hBB, 1); e_dma(0, 0, 8'hFF, 8'h00, 0, 8'h00);
    go(); rst = 1'b0; dma(0, 0, 8'h00, 8'h00, 0); cpu(1, 0, 8'hFF, 8'h00, 0); e_idle();
    go(); e_cpu(1, 0, 8'hFF, 8'h00, 1, 8'hAA);
    go(); cpu(0, 0, 8'h00, 8'h00, 0); e_idle();

    // Non-owner isolation: DMA write to 8'h10 waits for the CPU to release
    go(); cpu(1, 1, 8'h50, 8'h66, 1); e_idle();
    go(); dma(1, 1, 8'h10, 8'h55, 0); e_cpu(1, 1, 8'h50, 8'h66, 0, 8'h00);
    go(); cpu(1, 1, 8'h51, 8'h67, 1); e_cpu(1, 1, 8'h51, 8'h67, 0, 8'h00);
    go(); cpu(0, 0, 8'h51, 8'h67, 1); e_cpu(0, 0, 8'h51, 8'h00, 0, 8'h00);
    go(); cpu(0, 0, 8'h51, 8'h67, 0); e_cpu(0, 0, 8'h51, 8'h00, 0, 8'h00);
    go(); e_dma(1, 1, 8'h10, 8'h55, 0, 8'h00);
    go(); dma(0, 0, 8'h00, 8'h00, 0); cpu(1, 0, 8'h50, 8'h00, 0); e_idle();
    go(); e_cpu(1, 0, 8'h50, 8'h00, 1, 8'h66);
    go(); cpu(0, 0, 8'h00, 8'h00, 0); dma(1, 0, 8'h10, 8'h00, 0); e_idle();
    go(); e_dma(1, 0, 8'h10, 8'h00, 1, 8'h55);
    go(); dma(0, 0, 8'h00, 8'h00, 0); e_idle();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #6;
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 8-bit data memory port between two requesters: the CPU load/store path and a DMA/IO engine.
- Performs round-robin arbitration with optional locked bursts, capped at MAX_BURST beats to bound starvation.
- Drives the data memory's raddr/waddr/we/din and returns its combinational read data to the owning requester.
- Sits between the core's memory stage and the DataMemory instance.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MAX_BURST, 4, maximum beats per ownership; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU beat request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  beat address.
- cpu_wdata  in  DW  write data.
- cpu_lock  in  1  keep ownership after this beat.
- cpu_ack  out  1  beat completed this cycle.
- cpu_rdata  out  DW  read data, valid while cpu_ack=1 and cpu_we=0.
- dma_req, dma_we, dma_addr, dma_wdata, dma_lock, dma_ack, dma_rdata  same as the cpu_* ports.
- mem_raddr  out  AW  to DataMemory raddr.
- mem_waddr  out  AW  to DataMemory waddr.
- mem_we  out  1  to DataMemory we (memory writes on negedge clk).
- mem_din  out  DW  to DataMemory din.
- mem_dout  in  DW  from DataMemory dout (asynchronous read).
- owner  out  2  00 = none, 01 = CPU, 10 = DMA.

Behaviour:
- State machine: IDLE, OWN_CPU, OWN_DMA.
- Registers: state, burst counter cnt (clog2(MAX_BURST+1) bits), last_owner.
- Reset, applied at the rising edge with rst=1:
  - state=IDLE, cnt=0, last_owner=DMA, so the CPU wins the first tie.
  - While rst=1 in the current cycle, mem_we, cpu_ack and dma_ack are forced to 0 combinationally, so no negedge write occurs during a reset cycle.
- IDLE:
  - Outputs: acks=0, mem_we=0, mem_raddr/mem_waddr/mem_din=0, owner=00.
  - Edge decision: if only one req is high, go to that OWN state. If both are high, grant the requester that is not last_owner. Otherwise stay.
- OWN_x:
  - mem_raddr = mem_waddr = x_addr; mem_din = x_wdata; mem_we = x_req & x_we.
  - x_ack = x_req (combinational). x_rdata = mem_dout.
  - The non-owner's ack is 0 and its rdata is 0.
  - owner reflects the state.
- Beat: any OWN_x cycle with x_req=1.
  - Latency: request in IDLE at cycle N, ack in cycle N+1.
  - A write is committed at the negedge of the ack cycle. Read data is valid in the same cycle.
- Edge decision in OWN_x:
  - Beat with x_lock=1 and cnt+1 < MAX_BURST: stay; cnt += 1.
  - Beat with x_lock=0, or cnt+1 == MAX_BURST (forced release): release.
  - No beat and x_lock=1: stay; cnt unchanged (idle hold, no ack).
  - No beat and x_lock=0: release.
- Release:
  - last_owner = x; cnt = 0.
  - Next state = OWN_other if other_req=1 (direct hand-off, no IDLE bubble), else IDLE.
  - The released requester may re-request and is arbitrated again from IDLE.
- Other requester while x owns: its req is ignored (ack=0) until hand-off. It must hold req, addr, we and wdata stable until acked.
- Simultaneous release and re-request by x with other_req=0: go to IDLE, then re-grant x on the next edge.
- MAX_BURST=1: every beat releases; lock has no effect.
- Address width: no wrap handling; addresses pass through unmodified.
- Reset mid-burst: ownership is dropped; the beat in progress in the reset cycle is not acked and not written.

Test Plan:
- Single CPU write, then read:
  - cpu_req=1, we=1, addr=8'h1F, wdata=8'h07 in IDLE → cpu_ack=1 one cycle later, mem_we=1, then state IDLE.
  - Read of 8'h1F → cpu_rdata=8'h07 with cpu_ack.
- Tie after reset:
  - Both req high in the first cycle after reset → CPU granted first; on release, direct hand-off to DMA with no IDLE cycle; owner sequence 01, 10.
- Locked CPU burst with MAX_BURST=4 and DMA waiting:
  - cpu_lock=1, cpu_req held, dma_req=1 → exactly 4 consecutive cpu_ack cycles, then OWN_DMA.
  - Next tie after that → CPU (last_owner=DMA).
- Idle hold:
  - DMA owns with dma_lock=1, dma_req low for 3 cycles → owner stays 10, no acks, cnt unchanged.
  - dma_lock=0 → IDLE.
- Reset mid-operation:
  - rst=1 in the 2nd beat of a locked DMA write burst to 8'hFF → mem_we=0 and dma_ack=0 that cycle; memory[8'hFF] keeps its 1st-beat value; owner=00 after the edge.
- Non-owner isolation:
  - CPU owns; dma_req=1, dma_we=1, dma_addr=8'h10 → mem_waddr never 8'h10, dma_ack=0 until OWN_DMA.
